mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester channels (legal range 2..8).
REQ-002 Parameter DATA_WIDTH, default 32, data bus width in bits (multiple of 8).
REQ-003 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_read  input  NUM_PORTS  per-port read request.
REQ-007 req_write  input  NUM_PORTS  per-port write request.
REQ-008 req_byte_enable  input  NUM_PORTS x DATA_WIDTH/8  per-port byte enables.
REQ-009 req_address  input  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-010 req_wdata  input  NUM_PORTS x DATA_WIDTH  per-port write data.
REQ-011 req_resp  output  NUM_PORTS  per-port completion pulse.
REQ-012 req_rdata  output  DATA_WIDTH  read data, shared by all ports.
REQ-013 mem_read, mem_write  output  1 each  downstream memory commands.
REQ-014 mem_byte_enable  output  DATA_WIDTH/8; mem_address  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH.
REQ-015 mem_resp  input  1; mem_rdata  input  DATA_WIDTH  downstream completion and data.
REQ-016 busy  output  1; grant_idx  output  $clog2(NUM_PORTS)  debug/status.

Function
REQ-017 FSM has exactly two states, IDLE and BUSY.
REQ-018 A port is pending when req_read or req_write is high.
REQ-019 In IDLE with at least one pending port, the winner is the first pending port found searching upward from rr_ptr with wrap past NUM_PORTS-1 to 0.
REQ-020 On that edge: winner goes to grant_idx; its address, byte enables, wdata and operation are registered; FSM enters BUSY.
REQ-021 If req_read and req_write are both high on the winner, the operation is a read.
REQ-022 In BUSY, mem_read or mem_write is high per the registered operation; mem_address, mem_byte_enable and mem_wdata come only from registers.
REQ-023 Requester inputs are ignored in BUSY; deasserting a request after grant does not cancel it.
REQ-024 Latency: a request first pending in IDLE at cycle t drives the memory command from cycle t+1.
REQ-025 In BUSY with mem_resp high, req_resp[grant_idx] is high in the same cycle (combinational) and all other req_resp bits are low.
REQ-026 On that edge: FSM returns to IDLE, mem_read and mem_write go low, and rr_ptr = (grant_idx+1) mod NUM_PORTS.
REQ-027 Back-to-back: after a completion at cycle t, the next grant is sampled at t+1 and the next memory command starts at t+2.
REQ-028 req_rdata equals mem_rdata combinationally and is valid only when the port's req_resp is high.
REQ-029 mem_resp while in IDLE is ignored: no req_resp, no state change.
REQ-030 busy is high exactly in BUSY.
REQ-031 A port that stays pending waits at most NUM_PORTS-1 other grants.

Reset
REQ-032 On rst high, immediately and independent of clk:
- FSM = IDLE, rr_ptr = 0, grant_idx = 0
- mem_read, mem_write = 0
- mem_address, mem_byte_enable, mem_wdata registers = 0
- req_resp = 0
REQ-033 Reset in BUSY abandons the transaction with no req_resp; any mem_resp in the cycle after deassertion is ignored per REQ-029.
REQ-034 First arbitration after reset deassertion starts the search at port 0.

Structure
REQ-035 A shared package holds the arbiter state typedef (IDLE, BUSY) and the memory-operation typedef (read, write); the package is shared with the cache and top-level blocks.
REQ-036 Round-robin search lives in one combinational sub-module, rr_priority_select (inputs: pending vector, rr_ptr; outputs: winner index, any-valid).
REQ-037 No per-port state besides rr_ptr; storage scales with DATA_WIDTH and ADDR_WIDTH only.

Verification
REQ-038 N=2, port0 read addr 0x100, mem_resp 3 cycles later with rdata 0xDEADBEEF -> mem_read from t+1 at 0x100; req_resp[0] one cycle; req_rdata 0xDEADBEEF.
REQ-039 N=2, both ports request at t (p0 read 0x10, p1 write 0x20 wdata 0xA5A5A5A5 be 0xF) -> p0 served first, then p1 write at 0x20 from completion+2; rr_ptr ends at 0.
REQ-040 N=4, all ports continuously pending for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-041 p1 requests, is granted, and drops req_write the next cycle -> write to the latched address still completes; req_resp[1] pulses.
REQ-042 rst asserted mid-BUSY between clock edges -> mem_read/mem_write low immediately; no req_resp; stray mem_resp after release produces no response.
REQ-043 Port asserts req_read and req_write together -> mem_read high, mem_write low.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter, cache and top-level blocks.
// Holds the arbiter FSM state encoding and the memory-operation type.
package mem_arbiter_pkg;

   typedef logic [0:0] arb_state_t;

   localparam arb_state_t ARB_IDLE = 1'b0;
   localparam arb_state_t ARB_BUSY = 1'b1;

   typedef enum logic {
      MEM_OP_READ  = 1'b0,
      MEM_OP_WRITE = 1'b1
   } mem_op_e;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search: first pending port at or above rr_ptr_i,
// wrapping to 0. Ports: pending_i, rr_ptr_i -> winner_o, valid_o.
module rr_priority_select #(
   parameter int NUM_PORTS = 2,
   parameter int IW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] pending_i,
   input  logic [IW-1:0]        rr_ptr_i,
   output logic [IW-1:0]        winner_o,
   output logic                 valid_o
);

   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      winner_o = '0;
      valid_o  = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         // one spare bit so rr_ptr + i never overflows before the wrap
         sum = {1'b0, rr_ptr_i} + (IW+1)'(i);
         if (sum >= (IW+1)'(NUM_PORTS)) begin
            sum = sum - (IW+1)'(NUM_PORTS);
         end
         idx = sum[IW-1:0];
         if (!valid_o && pending_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS requesters.
// Ports: per-port req_* in, req_resp/req_rdata out; mem_* command/response;
// busy and grant_idx for status.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0]                req_read,
   input  logic [NUM_PORTS-1:0]                req_write,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_byte_enable,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]                req_resp,
   output logic [DATA_WIDTH-1:0]               req_rdata,
   output logic                                mem_read,
   output logic                                mem_write,
   output logic [DATA_WIDTH/8-1:0]             mem_byte_enable,
   output logic [ADDR_WIDTH-1:0]               mem_address,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   input  logic                                mem_resp,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   output logic                                busy,
   output logic [$clog2(NUM_PORTS)-1:0]        grant_idx
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int IW = $clog2(NUM_PORTS);

   arb_state_t            state_q, state_d;
   mem_op_e               op_q, op_d;
   logic [IW-1:0]         grant_q, grant_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BW-1:0]         be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
   logic [BW-1:0]         be_arr    [NUM_PORTS];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign addr_arr[p]  = req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign be_arr[p]    = req_byte_enable[p*BW +: BW];
      assign wdata_arr[p] = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
   end

   logic [IW-1:0] win;
   logic          win_valid;

   rr_priority_select #(
      .NUM_PORTS (NUM_PORTS),
      .IW        (IW)
   ) u_rr_sel (
      .pending_i (req_read | req_write),
      .rr_ptr_i  (rr_ptr_q),
      .winner_o  (win),
      .valid_o   (win_valid)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (win_valid) begin
               state_d = ARB_BUSY;
               grant_d = win;
               addr_d  = addr_arr[win];
               be_d    = be_arr[win];
               wdata_d = wdata_arr[win];
               // read has priority when both are raised together
               op_d    = req_read[win] ? MEM_OP_READ : MEM_OP_WRITE;
            end
         end
         ARB_BUSY: begin
            if (mem_resp) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = (grant_q == IW'(NUM_PORTS-1)) ? '0
                                                        : grant_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         op_q     <= MEM_OP_READ;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
      end
   end

   assign busy            = (state_q == ARB_BUSY);
   assign mem_read        = busy && (op_q == MEM_OP_READ);
   assign mem_write       = busy && (op_q == MEM_OP_WRITE);
   assign mem_address     = addr_q;
   assign mem_byte_enable = be_q;
   assign mem_wdata       = wdata_q;
   assign grant_idx       = grant_q;
   assign req_rdata       = mem_rdata;

   // completion is forwarded in the same cycle; mem_resp in IDLE is dropped
   always_comb begin
      req_resp = '0;
      if (busy && mem_resp) begin
         req_resp[grant_q] = 1'b1;
      end
   end

endmodule
